// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: character FIFO between the SoC UART transmit port and the console printer.
// Bytes are accepted under a valid/ready handshake. They are drained as one-cycle out_valid
// pulses, with DRAIN_GAP idle cycles forced after every emitted byte.
// A byte with bit 7 set is the end-of-simulation marker. Once the marker is accepted, input is
// refused, the queue drains, the marker is emitted last, and the block stays idle until reset.
//
// Optional feature (macro undefined by default):
//   UART_TX_BUFFER_CRLF_EN - a popped 0x0A is emitted as 0x0D followed by 0x0A.
//
// Ports:
//   clock     - sole clock, rising edge
//   reset     - asynchronous active-low reset
//   in_valid  - SoC presents in_ch
//   in_ch     - byte from the SoC; bit 7 set marks end of simulation
//   in_ready  - buffer accepts in_ch this cycle
//   out_valid - one-cycle pulse per emitted byte (registered)
//   out_ch    - emitted byte (registered); only meaningful with out_valid
//   level     - FIFO occupancy
//   done      - marker has been emitted; sticky until reset
module uart_tx_buffer #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned DRAIN_GAP = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [7:0]             in_ch,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [7:0]             out_ch,
   output logic [$clog2(DEPTH):0] level,
   output logic                   done
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned GapW = (DRAIN_GAP > 0) ? $clog2(DRAIN_GAP + 1) : 1;
   localparam logic [PtrW:0]   LevelFull = (PtrW + 1)'(DEPTH);
   localparam logic [GapW-1:0] GapLoad   = GapW'(DRAIN_GAP);

   typedef enum logic [1:0] {StRun, StEnding, StDone} state_e;

   state_e          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   level_q, level_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic            out_valid_q, out_valid_d;
   logic [7:0]      out_ch_q, out_ch_d;
   logic            done_q, done_d;

   logic            push, emit, pop, marker_out;
   logic [7:0]      head, emit_ch;

   assign head = mem_q[rd_ptr_q];
   assign push = in_valid && in_ready;
   assign emit = (level_q != '0) && (gap_q == '0);

`ifdef UART_TX_BUFFER_CRLF_EN
   logic cr_sent_q, cr_sent_d;
   logic cr_slot;

   // First slot for a queued LF carries the CR; the entry stays queued until its LF slot.
   assign cr_slot = (head == 8'h0A) && !cr_sent_q;
   assign emit_ch = cr_slot ? 8'h0D : head;
   assign pop     = emit && !cr_slot;

   always_comb begin
      cr_sent_d = cr_sent_q;
      if (emit) begin
         cr_sent_d = cr_slot;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cr_sent_q <= 1'b0;
      end else begin
         cr_sent_q <= cr_sent_d;
      end
   end
`else
   assign emit_ch = head;
   assign pop     = emit;
`endif

   assign marker_out = pop && head[7];

   // FSM: state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:    if (push && in_ch[7]) state_d = StEnding;
         StEnding: if (marker_out)       state_d = StDone;
         StDone:                         state_d = StDone;
         default:                        state_d = StRun;
      endcase
   end

   // FSM: outputs; depends on registered state only, never on in_valid
   always_comb begin
      in_ready = (state_q == StRun) && (level_q != LevelFull);
   end

   // FIFO and drain datapath
   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d     = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (!push && pop) begin
         level_d = level_q - 1'b1;
      end
      gap_d = gap_q;
      if (emit) begin
         gap_d = GapLoad;
      end else if (gap_q != '0) begin
         gap_d = gap_q - 1'b1;
      end
      out_valid_d = emit;
      out_ch_d    = emit ? emit_ch : out_ch_q;
      done_d      = done_q || marker_out;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         gap_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= 8'h00;
         done_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         gap_q       <= gap_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         done_q      <= done_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by level_q alone.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_ch;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign level     = level_q;
   assign done      = done_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;

   // Instance A: DEPTH 16, DRAIN_GAP 0
   logic       a_in_valid = 1'b0;
   logic [7:0] a_in_ch    = 8'h00;
   logic       a_in_ready, a_out_valid, a_done;
   logic [7:0] a_out_ch;
   logic [4:0] a_level;

   // Instance B: DEPTH 4, DRAIN_GAP 3
   logic       b_in_valid = 1'b0;
   logic [7:0] b_in_ch    = 8'h00;
   logic       b_in_ready, b_out_valid, b_done;
   logic [7:0] b_out_ch;
   logic [2:0] b_level;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Pulses seen on instance B
   logic [7:0] qch [$];
   int         qcyc [$];
   int         qlvl [$];

   always #5 clock = ~clock;

   uart_tx_buffer #(.DEPTH(16), .DRAIN_GAP(0)) u_dut_a (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (a_in_valid),
      .in_ch     (a_in_ch),
      .in_ready  (a_in_ready),
      .out_valid (a_out_valid),
      .out_ch    (a_out_ch),
      .level     (a_level),
      .done      (a_done)
   );

   uart_tx_buffer #(.DEPTH(4), .DRAIN_GAP(3)) u_dut_b (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (b_in_valid),
      .in_ch     (b_in_ch),
      .in_ready  (b_in_ready),
      .out_valid (b_out_valid),
      .out_ch    (b_out_ch),
      .level     (b_level),
      .done      (b_done)
   );

   always begin
      @(posedge clock);
      cyc++;
      #1;
      if (b_out_valid) begin
         qch.push_back(b_out_ch);
         qcyc.push_back(cyc);
         qlvl.push_back(int'(b_level));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic push_b(input logic [7:0] ch);
      int n = 0;
      b_in_valid = 1'b1;
      b_in_ch    = ch;
      while (!b_in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) begin
         chk($sformatf("push_b_timeout_%0h", ch), 32'd0, 32'd1);
      end else begin
         @(negedge clock);
      end
      b_in_valid = 1'b0;
   endtask

   task automatic wait_pulses(input int n, input string name);
      int t = 0;
      while (qch.size() < n && t < 200) begin
         @(posedge clock);
         #2;
         t++;
      end
      chk(name, qch.size(), n);
   endtask

   typedef struct {
      logic       vld;
      logic [7:0] ch;
      logic       rdy;
      logic       ov;
      logic [7:0] och;
      logic [4:0] lvl;
      logic       dn;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int base;
      logic [7:0] exp_ch [3];
      int         exp_lv [3];
      int         n_exp;

      // Row: inputs before the edge, expected outputs just after it (instance A).
      tbl[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 5'd0, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
      tbl[3]  = '{1'b1, 8'h61, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
      tbl[4]  = '{1'b1, 8'h62, 1'b1, 1'b1, 8'h61, 5'd1, 1'b0};
      tbl[5]  = '{1'b1, 8'h63, 1'b1, 1'b1, 8'h62, 5'd1, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h63, 5'd0, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
      tbl[8]  = '{1'b1, 8'h4F, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
      tbl[9]  = '{1'b1, 8'h4B, 1'b1, 1'b1, 8'h4F, 5'd1, 1'b0};
      tbl[10] = '{1'b1, 8'h80, 1'b0, 1'b1, 8'h4B, 5'd1, 1'b0};
      tbl[11] = '{1'b1, 8'h58, 1'b0, 1'b1, 8'h80, 5'd0, 1'b1};
      tbl[12] = '{1'b1, 8'h58, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};

      // Reset held with input offered
      a_in_valid = 1'b1; a_in_ch = 8'h41;
      b_in_valid = 1'b1; b_in_ch = 8'h41;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk($sformatf("rst%0d.a_out_valid", i), a_out_valid, 1'b0);
         chk($sformatf("rst%0d.a_level", i), a_level, 5'd0);
         chk($sformatf("rst%0d.a_done", i), a_done, 1'b0);
         chk($sformatf("rst%0d.b_level", i), b_level, 3'd0);
      end
      reset = 1'b1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      #1;
      chk("post_rst.a_in_ready", a_in_ready, 1'b1);
      chk("post_rst.b_in_ready", b_in_ready, 1'b1);
      @(negedge clock);
      chk("post_rst.a_level", a_level, 5'd0);
      chk("post_rst.a_out_valid", a_out_valid, 1'b0);

      // Table-driven: single byte, streaming, end marker on instance A
      for (int i = 0; i < 13; i++) begin
         a_in_valid = tbl[i].vld;
         a_in_ch    = tbl[i].ch;
         @(posedge clock);
         #1;
         chk($sformatf("vec%0d.in_ready", i), a_in_ready, tbl[i].rdy);
         chk($sformatf("vec%0d.out_valid", i), a_out_valid, tbl[i].ov);
         if (tbl[i].ov) chk($sformatf("vec%0d.out_ch", i), a_out_ch, tbl[i].och);
         chk($sformatf("vec%0d.level", i), a_level, tbl[i].lvl);
         chk($sformatf("vec%0d.done", i), a_done, tbl[i].dn);
      end
      // Marker emitted: 0x58 stays refused, nothing more comes out
      for (int i = 0; i < 100; i++) begin
         @(posedge clock);
         #1;
         chk($sformatf("quiet%0d.out_valid", i), a_out_valid, 1'b0);
         chk($sformatf("quiet%0d.done", i), a_done, 1'b1);
      end
      chk("quiet.level", a_level, 5'd0);
      a_in_valid = 1'b0;
      @(negedge clock);

      // Full FIFO on instance B (DEPTH 4, gap 3)
      base = qch.size();
      for (int i = 0; i < 5; i++) push_b(8'h30 + 8'(i));
      chk("full.level", b_level, 3'd4);
      chk("full.in_ready", b_in_ready, 1'b0);
      push_b(8'h35);
      wait_pulses(base + 6, "full.pulse_count");
      for (int i = 0; i < 6; i++) begin
         if (base + i < qch.size()) begin
            chk($sformatf("full.ch%0d", i), qch[base+i], 8'h30 + 8'(i));
            if (i > 0) chk($sformatf("full.gap%0d", i), qcyc[base+i] - qcyc[base+i-1], 4);
         end
      end
      repeat (6) @(negedge clock);

      // LF handling on instance B
`ifdef UART_TX_BUFFER_CRLF_EN
      exp_ch = '{8'h0D, 8'h0A, 8'h42};
      exp_lv = '{2, 1, 0};
      n_exp  = 3;
`else
      exp_ch = '{8'h0A, 8'h42, 8'h00};
      exp_lv = '{1, 0, 0};
      n_exp  = 2;
`endif
      base = qch.size();
      push_b(8'h0A);
      push_b(8'h42);
      wait_pulses(base + n_exp, "lf.pulse_count");
      repeat (8) @(negedge clock);
      chk("lf.no_extra", qch.size(), base + n_exp);
      for (int i = 0; i < n_exp; i++) begin
         if (base + i < qch.size()) begin
            chk($sformatf("lf.ch%0d", i), qch[base+i], exp_ch[i]);
            chk($sformatf("lf.level%0d", i), qlvl[base+i], exp_lv[i]);
            if (i > 0) chk($sformatf("lf.gap%0d", i), qcyc[base+i] - qcyc[base+i-1], 4);
         end
      end

      // Reset in the middle of a drain
      base = qch.size();
      push_b(8'h11);
      push_b(8'h22);
      push_b(8'h33);
      wait_pulses(base + 1, "mid.first_pulse");
      chk("mid.first_ch", qch[base], 8'h11);
      #1;
      reset = 1'b0;
      #1;
      chk("mid.out_valid", b_out_valid, 1'b0);
      chk("mid.out_ch", b_out_ch, 8'h00);
      chk("mid.level", b_level, 3'd0);
      chk("mid.a_done", a_done, 1'b0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      chk("mid.no_emit_after", qch.size(), base + 1);
      chk("mid.b_in_ready", b_in_ready, 1'b1);
      chk("mid.a_in_ready", a_in_ready, 1'b1);
      chk("mid.b_level_end", b_level, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
